// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline: load data selection and extension,
// LWL/LWR byte-lane merging, and a one-entry read-data hold buffer for back-pressure.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [95:0] es_to_ms_bus,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [85:0] ms_to_ws_bus,
    output logic [9:0]  stall_ms_bus,
    output logic [32:0] forward_ms_bus,
    output logic        ms_exc_eret
);

    logic        ms_valid;
    logic        ms_ready_go;
    logic [95:0] ms_bus;
    logic        first;
    logic        buf_valid;
    logic [31:0] buf_data;

    logic        bd;
    logic        exc_sys;
    logic        eret_flush;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        res_from_mem;
    logic [6:0]  inst_load;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        unused_bits;

    logic [1:0]  a;
    logic [31:0] rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;
    logic [3:0]  load_we;
    logic [3:0]  rf_we;
    logic [31:0] final_result;
    logic        inst_lwl;
    logic        inst_lwr;
    logic        fwd_valid;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms_bus <= es_to_ms_bus;
        end
    end

    // SRAM data is only presented in the first cycle; hold it if writeback stalls us.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            first     <= 1'b0;
            buf_valid <= 1'b0;
        end else begin
            first <= es_to_ms_valid && ms_allowin;
            if (ms_valid && ws_allowin) begin
                buf_valid <= 1'b0;
            end else if (first && !ws_allowin) begin
                buf_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (first && !ws_allowin) begin
            buf_data <= data_sram_rdata;
        end
    end

    assign bd           = ms_bus[95];
    assign exc_sys      = ms_bus[94];
    assign eret_flush   = ms_bus[93];
    assign cp0_wen      = ms_bus[92];
    assign res_from_cp0 = ms_bus[91];
    assign cp0_addr     = ms_bus[90:83];
    assign res_from_mem = ms_bus[82];
    assign inst_load    = ms_bus[81:75];
    assign gr_we        = ms_bus[69];
    assign dest         = ms_bus[68:64];
    assign alu_result   = ms_bus[63:32];
    assign pc           = ms_bus[31:0];
    assign unused_bits  = ^ms_bus[74:70];

    assign inst_lwl = inst_load[5];
    assign inst_lwr = inst_load[6];
    assign a        = alu_result[1:0];
    assign rdata    = buf_valid ? buf_data : data_sram_rdata;
    assign half_sel = a[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        byte_sel = rdata[7:0];
        case (a)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    always_comb begin
        load_result = rdata;
        load_we     = {4{gr_we}};
        if (inst_load[0]) begin
            load_result = {{24{byte_sel[7]}}, byte_sel};
        end else if (inst_load[1]) begin
            load_result = {24'd0, byte_sel};
        end else if (inst_load[2]) begin
            load_result = {{16{half_sel[15]}}, half_sel};
        end else if (inst_load[3]) begin
            load_result = {16'd0, half_sel};
        end else if (inst_lwl) begin
            case (a)
                2'd0:    begin load_we = 4'b1000; load_result = rdata << 24; end
                2'd1:    begin load_we = 4'b1100; load_result = rdata << 16; end
                2'd2:    begin load_we = 4'b1110; load_result = rdata << 8;  end
                default: begin load_we = 4'b1111; load_result = rdata;       end
            endcase
        end else if (inst_lwr) begin
            case (a)
                2'd0:    begin load_we = 4'b1111; load_result = rdata;       end
                2'd1:    begin load_we = 4'b0111; load_result = rdata >> 8;  end
                2'd2:    begin load_we = 4'b0011; load_result = rdata >> 16; end
                default: begin load_we = 4'b0001; load_result = rdata >> 24; end
            endcase
        end
    end

    assign rf_we        = exc_sys ? 4'b0000 : load_we;
    assign final_result = res_from_mem ? load_result : alu_result;

    // Partial-word writes cannot be forwarded; decode stalls on stall_ms_bus instead.
    assign fwd_valid = ms_valid && !res_from_cp0 && !inst_lwl && !inst_lwr;

    assign ms_to_ws_bus   = {bd, exc_sys, eret_flush, cp0_wen, res_from_cp0, cp0_addr,
                             rf_we, dest, final_result, pc};
    assign stall_ms_bus   = {{5{ms_valid && gr_we}}, dest};
    assign forward_ms_bus = {fwd_valid, final_result};
    assign ms_exc_eret    = ms_valid && (exc_sys || eret_flush);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed loads, stall buffering, flush/reset, random loads.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [95:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [85:0] ms_to_ws_bus;
    logic [9:0]  stall_ms_bus;
    logic [32:0] forward_ms_bus;
    logic        ms_exc_eret;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] LB = 7'b0000001, LBU = 7'b0000010, LH = 7'b0000100,
                           LHU = 7'b0001000, LW = 7'b0010000, LWL = 7'b0100000,
                           LWR = 7'b1000000;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .data_sram_rdata(data_sram_rdata),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .stall_ms_bus   (stall_ms_bus),
        .forward_ms_bus (forward_ms_bus),
        .ms_exc_eret    (ms_exc_eret)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] mk(input logic exc, input logic eret, input logic rfc0,
                                       input logic rfm, input logic [6:0] ld, input logic gr,
                                       input logic [4:0] dst, input logic [31:0] alu,
                                       input logic [31:0] pcv);
        return {1'b0, exc, eret, 1'b0, rfc0, 8'h05, rfm, ld, 5'b0, gr, dst, alu, pcv};
    endfunction

    // Reference: byte-lane view of the register write, from the MIPS load rules.
    function automatic void model(input logic [95:0] b, input logic [31:0] rd,
                                  output logic [3:0] we, output logic [31:0] res);
        logic [6:0]  ld;
        logic [7:0]  by [4];
        logic [7:0]  rb [4];
        logic [15:0] hw;
        logic [31:0] lr;
        int a;
        ld = b[81:75];
        a  = int'(b[33:32]);
        for (int i = 0; i < 4; i++) by[i] = rd[8*i +: 8];
        hw = (a >= 2) ? rd[31:16] : rd[15:0];
        we = {4{b[69]}};
        lr = rd;
        if (ld[0])      lr = 32'(signed'(by[a]));
        else if (ld[1]) lr = 32'(by[a]);
        else if (ld[2]) lr = 32'(signed'(hw));
        else if (ld[3]) lr = 32'(hw);
        else if (ld[5] || ld[6]) begin
            we = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                rb[i] = 8'h00;
                if (ld[5] && i >= 3 - a) begin we[i] = 1'b1; rb[i] = by[i - (3 - a)]; end
                if (ld[6] && i < 4 - a)  begin we[i] = 1'b1; rb[i] = by[i + a]; end
            end
            lr = {rb[3], rb[2], rb[1], rb[0]};
        end
        res = b[82] ? lr : b[63:32];
        if (b[94]) we = 4'b0000;
    endfunction

    // Sends one instruction through an empty stage, holding writeback off for 'stall' cycles.
    task automatic issue(input logic [95:0] b, input logic [31:0] rd, input int stall,
                         input logic [31:0] garbage, input logic rand_garbage,
                         output logic [31:0] obs_res, output logic [3:0] obs_we);
        logic [3:0]  ewe;
        logic [31:0] eres;
        logic [85:0] ebus;
        model(b, rd, ewe, eres);
        ebus = {b[95:91], b[90:83], ewe, b[68:64], eres, b[31:0]};
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        ws_allowin     = (stall == 0);
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = $urandom();
        data_sram_rdata = rd;
        #1;
        for (int k = 0; k < stall; k++) begin
            checks++;
            if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: allowin=%b valid=%b, required allowin=0 valid=1",
                         k, ms_allowin, ms_to_ws_valid);
            end
            @(negedge clk);
            data_sram_rdata = rand_garbage ? $urandom() : garbage;
        end
        ws_allowin = 1'b1;
        #1;
        obs_res = ms_to_ws_bus[63:32];
        obs_we  = ms_to_ws_bus[72:69];
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== ebus) begin
            errors++;
            $display("FAIL ws_bus: valid=%b bus=%h, required valid=1 bus=%h",
                     ms_to_ws_valid, ms_to_ws_bus, ebus);
        end
        checks++;
        if (forward_ms_bus !== {!b[91] && !b[80] && !b[81], eres}) begin
            errors++;
            $display("FAIL fwd_bus: got %h, required %h", forward_ms_bus,
                     {!b[91] && !b[80] && !b[81], eres});
        end
        checks++;
        if (stall_ms_bus !== {{5{b[69]}}, b[68:64]} || ms_exc_eret !== (b[94] || b[93])) begin
            errors++;
            $display("FAIL stall_exc: stall=%h exc=%b, required stall=%h exc=%b", stall_ms_bus,
                     ms_exc_eret, {{5{b[69]}}, b[68:64]}, b[94] || b[93]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || dut.buf_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: valid=%b buf_valid=%b, required 0 0", ms_to_ws_valid,
                     dut.buf_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1, 1, 0, 1, LW, 1, 5'd3, 32'h0, 32'h0); data_sram_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || stall_ms_bus[9:5] !== 5'd0 || forward_ms_bus[32] !== 1'b0
            || ms_exc_eret !== 1'b0 || ms_allowin !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b stall_en=%b fwd=%b exc=%b allowin=%b, required 0 0 0 0 1",
                     ms_to_ws_valid, stall_ms_bus[9:5], forward_ms_bus[32], ms_exc_eret, ms_allowin);
        end
        checks++;
        if (dut.first !== 1'b0 || dut.buf_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: first=%b buf_valid=%b, required 0 0", dut.first, dut.buf_valid);
        end
        es_to_ms_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] r;
        logic [3:0]  w;
        issue(mk(0, 0, 0, 1, LW, 1, 5'd4, 32'h100, 32'hBFC0_0000), 32'h8899AABB, 0, 0, 0, r, w);
        checks++;
        if (r !== 32'h8899AABB || w !== 4'b1111) begin
            errors++; $display("FAIL lw: result=%h we=%b, required 8899aabb 1111", r, w);
        end
        issue(mk(0, 0, 0, 1, LB, 1, 5'd5, 32'h101, 32'h4), 32'h11228344, 0, 0, 0, r, w);
        checks++;
        if (r !== 32'hFFFFFF83) begin
            errors++; $display("FAIL lb: result=%h, required ffffff83", r);
        end
        issue(mk(0, 0, 0, 1, LBU, 1, 5'd5, 32'h101, 32'h8), 32'h11228344, 0, 0, 0, r, w);
        checks++;
        if (r !== 32'h00000083) begin
            errors++; $display("FAIL lbu: result=%h, required 00000083", r);
        end
        issue(mk(0, 0, 0, 1, LH, 1, 5'd6, 32'h102, 32'hC), 32'h80FF0000, 0, 0, 0, r, w);
        checks++;
        if (r !== 32'hFFFF80FF) begin
            errors++; $display("FAIL lh: result=%h, required ffff80ff", r);
        end
        issue(mk(0, 0, 0, 1, LWL, 1, 5'd7, 32'h201, 32'h10), 32'hAABBCCDD, 0, 0, 0, r, w);
        checks++;
        if (r !== 32'hCCDD0000 || w !== 4'b1100) begin
            errors++; $display("FAIL lwl: result=%h we=%b, required ccdd0000 1100", r, w);
        end
        issue(mk(0, 0, 0, 1, LWR, 1, 5'd7, 32'h202, 32'h14), 32'hAABBCCDD, 0, 0, 0, r, w);
        checks++;
        if (r !== 32'h0000AABB || w !== 4'b0011) begin
            errors++; $display("FAIL lwr: result=%h we=%b, required 0000aabb 0011", r, w);
        end
    endtask

    task automatic test_stall_buffer();
        logic [31:0] r;
        logic [3:0]  w;
        issue(mk(0, 0, 0, 1, LW, 1, 5'd9, 32'h300, 32'h20), 32'h12345678, 3, 32'hDEADBEEF, 0, r, w);
        checks++;
        if (r !== 32'h12345678) begin
            errors++; $display("FAIL stall_hold: result=%h, required 12345678", r);
        end
    endtask

    task automatic test_syscall_flush();
        logic [31:0] r;
        logic [3:0]  w;
        issue(mk(1, 0, 0, 0, 7'd0, 1, 5'd2, 32'h77, 32'h30), 32'h0, 0, 0, 0, r, w);
        checks++;
        if (w !== 4'b0000) begin
            errors++; $display("FAIL syscall_we: we=%b, required 0000", w);
        end
        @(negedge clk);
        es_to_ms_valid = 1'b1; flush = 1'b1; ws_allowin = 1'b1;
        es_to_ms_bus = mk(0, 1, 0, 0, 7'd0, 1, 5'd2, 32'h0, 32'h34);
        @(negedge clk);
        es_to_ms_valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || dut.buf_valid !== 1'b0 || ms_exc_eret !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_valid: valid=%b buf_valid=%b exc=%b, required 0 0 0",
                     ms_to_ws_valid, dut.buf_valid, ms_exc_eret);
        end
        // Flush a load whose data is held in the buffer; the next load must see live data.
        @(negedge clk);
        es_to_ms_valid = 1'b1; ws_allowin = 1'b0;
        es_to_ms_bus = mk(0, 0, 0, 1, LW, 1, 5'd8, 32'h400, 32'h38);
        @(negedge clk);
        es_to_ms_valid = 1'b0; data_sram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        checks++;
        if (dut.buf_valid !== 1'b1) begin
            errors++; $display("FAIL buf_capture: buf_valid=%b, required 1", dut.buf_valid);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || dut.buf_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_buf: valid=%b buf_valid=%b, required 0 0", ms_to_ws_valid,
                     dut.buf_valid);
        end
        issue(mk(0, 0, 0, 1, LW, 1, 5'd8, 32'h404, 32'h3C), 32'h0BADF00D, 0, 0, 0, r, w);
        checks++;
        if (r !== 32'h0BADF00D) begin
            errors++; $display("FAIL post_flush_load: result=%h, required 0badf00d", r);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        es_to_ms_valid = 1'b1; ws_allowin = 1'b0;
        es_to_ms_bus = mk(0, 0, 0, 1, LW, 1, 5'd11, 32'h500, 32'h40);
        @(negedge clk);
        es_to_ms_valid = 1'b0; data_sram_rdata = 32'h55AA55AA;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || stall_ms_bus[9:5] !== 5'd0 || dut.buf_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b stall_en=%b buf_valid=%b, required 0 0 0",
                     ms_to_ws_valid, stall_ms_bus[9:5], dut.buf_valid);
        end
        ws_allowin = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [3:0]  w;
        logic [6:0]  ld;
        logic [95:0] b;
        int kind;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 7));
            ld   = (kind < 7) ? 7'(1 << kind) : 7'd0;
            b = mk($urandom_range(0, 15) == 0, 1'b0, (kind == 7) && ($urandom_range(0, 3) == 0),
                   kind < 7, ld, 1'($urandom()), 5'($urandom()), $urandom(), $urandom());
            issue(b, $urandom(), int'($urandom_range(0, 3)), 0, 1, r, w);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall_buffer();
        test_syscall_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth stage of the 5-stage MIPS pipeline. It sits between the execute stage (upstream) and the writeback stage (downstream).
- Receives the 96-bit execute→memory bus and the synchronous data-SRAM read data. The SRAM read data returns one cycle after execute presents the address.
- Performs load byte/half selection, sign/zero extension, and LWL/LWR partial-word merging expressed as per-byte register write enables.
- Emits the writeback bus, hazard stall/forward buses, and an exception/eret kill signal back to execute.
- Holds SRAM read data in a one-entry buffer while writeback back-pressures.

Parameters:
- None. All widths are fixed by the pipeline bus definitions.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  exception/eret flush from writeback; kills this stage's content
- ws_allowin  in  1  writeback can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  execute presents valid instruction
- es_to_ms_bus  in  96  {bd[95], exc_sys[94], eret_flush[93], cp0_wen[92], res_from_cp0[91], cp0_addr[90:83], res_from_mem[82], inst_load[81:75], ld_extd_op[74:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  SRAM read data; valid in the first cycle an instruction occupies this stage
- ms_to_ws_valid  out  1  valid to writeback
- ms_to_ws_bus  out  86  {bd[85], exc_sys[84], eret_flush[83], cp0_wen[82], res_from_cp0[81], cp0_addr[80:73], rf_we[72:69], dest[68:64], final_result[63:32], pc[31:0]}
- stall_ms_bus  out  10  {{5{ms_valid&&gr_we}}, dest}
- forward_ms_bus  out  33  {fwd_valid, final_result}
- ms_exc_eret  out  1  ms_valid && (exc_sys || eret_flush); drives one bit of execute's exc/eret kill bus

Behaviour:
- Pipeline register:
  - On reset or flush: ms_valid←0.
  - Otherwise, if ms_allowin: ms_valid←es_to_ms_valid.
  - Bus register loads when es_to_ms_valid && ms_allowin.
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- Reset values: ms_valid=0, first=0, buf_valid=0. All valid-qualified outputs (ms_to_ws_valid, stall enables, fwd_valid, ms_exc_eret) are 0.
- Read-data capture:
  - first←1 on the cycle an instruction is loaded. It clears on the next clock.
  - If first && !ws_allowin, then buf←data_sram_rdata and buf_valid←1.
  - buf_valid clears when the instruction leaves (ms_valid && ws_allowin), or on flush or reset.
  - Effective rdata = buf_valid ? buf : data_sram_rdata.
- inst_load one-hot, bit0..6 = lb, lbu, lh, lhu, lw, lwl, lwr. ld_extd_op is ignored.
- a = alu_result[1:0].
- Load result selection:
  - lb/lbu: byte a, sign-/zero-extended.
  - lh/lhu: half a[1], sign-/zero-extended.
  - lw: rdata.
- LWL (rf_we / data):
  - a=0: 1000 / rdata<<24
  - a=1: 1100 / rdata<<16
  - a=2: 1110 / rdata<<8
  - a=3: 1111 / rdata
- LWR (rf_we / data):
  - a=0: 1111 / rdata
  - a=1: 0111 / rdata>>8
  - a=2: 0011 / rdata>>16
  - a=3: 0001 / rdata>>24
- Non-LWL/LWR: rf_we = {4{gr_we}}. rf_we is forced to 0 when exc_sys.
- final_result = res_from_mem ? load_result : alu_result. When res_from_cp0, writeback substitutes the CP0 data.
- fwd_valid = ms_valid && !res_from_cp0 && !lwl && !lwr. Partial writes are not forwarded; decode stalls on stall_ms_bus instead.
- Misaligned addresses are not checked here.
- Simultaneous flush and es_to_ms_valid: flush wins; ms_valid=0 next cycle.
- Reset mid-operation: valid and buffer clear; the register payload is don't-care.

Test Plan:
- lw at addr 0x100, rdata=0x8899AABB, ws_allowin=1 → next cycle ms_to_ws_valid=1, final_result=0x8899AABB, rf_we=1111, fwd_valid=1.
- lb a=1, rdata=0x1122_8344 → result 0xFFFFFF83. lbu same → 0x00000083. lh a=2, rdata=0x80FF0000 → 0xFFFF80FF.
- lwl a=1, rdata=0xAABBCCDD → rf_we=1100, result 0xCCDD0000, fwd_valid=0. lwr a=2 → rf_we=0011, result 0x0000AABB.
- lw loaded with ws_allowin=0 for 3 cycles, SRAM rdata changes to 0xDEADBEEF after the first cycle (original 0x12345678) → ms_allowin=0 throughout; on release, final_result=0x12345678.
- syscall instruction (exc_sys=1, gr_we=1) → ms_exc_eret=1, rf_we=0000. Assert flush the same cycle as es_to_ms_valid → ms_valid=0, buf_valid=0 next cycle.
- Reset asserted while a buffered load is held → ms_to_ws_valid=0, stall_ms_bus[9:5]=0 next cycle.
